lap_sram_sequencer: RTL and testbench

APB master that moves stopwatch lap records into the sram_rw APB slave and shares that slave's single APB port between lap writes and host lap reads. It captures each lap_store event from the stopwatch into a small FIFO and drains the FIFO as APB write transfers. It arbitrates those writes against host read requests and returns read data and error status to the host.

---
 rtl/lap_sram_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_lap_sram_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lap_sram_sequencer.sv
// rtl/lap_sram_sequencer.sv - lap FIFO plus APB master sharing sram_rw between lap writes and host reads
// Optional LAP_SEQ_OVERWRITE_EN: a full FIFO loses its oldest lap instead of the incoming one.
module lap_sram_sequencer #(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        iLAP_STORE,
    input  logic [25:0] iLAP,
    input  logic [3:0]  iLAP_ADDR,
    input  logic        iRD_REQ,
    input  logic [3:0]  iRD_ADDR,
    input  logic        iERR_CLR,
    output logic        oRD_VALID,
    output logic [25:0] oRD_DATA,
    output logic        oRD_BUSY,
    output logic        oFIFO_FULL,
    output logic        oDROP,
    output logic        oERR,
    output logic        oPSEL,
    output logic        oPENABLE,
    output logic        oPWRITE,
    output logic [3:0]  oPSTRB,
    output logic [15:0] oPADDR,
    output logic [31:0] oPWDATA,
    input  logic [31:0] iPRDATA,
    input  logic        iPREADY,
    input  logic        iPSLVERR
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;
    state_t state, next_state;

    logic [29:0] fifo_mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count;
    logic [29:0] head;
    logic [3:0]  slot;
    logic        full, wr_pend, pick_write, grant, xfer_done;
    logic        lap_q, push_evt, push_ok, pop, adv_rd, drop, drop_q;
    logic        rd_pend, rd_valid_q, err_q;
    logic [3:0]  rd_addr_q;
    logic [25:0] rd_data_q;

    logic        psel_q, penable_q, pwrite_q;
    logic [3:0]  pstrb_q;
    logic [15:0] paddr_q;
    logic [31:0] pwdata_q;
    logic        psel_d, penable_d, pwrite_d;
    logic [3:0]  pstrb_d;
    logic [15:0] paddr_d;
    logic [31:0] pwdata_d;

    logic unused_bits;
    assign unused_bits = &{1'b0, iPRDATA[31:26]};

    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == FULL_CNT);
    assign wr_pend   = (count != '0);
    assign head      = fifo_mem[rd_ptr[AW-1:0]];
    assign push_evt  = iLAP_STORE & ~lap_q;
    assign xfer_done = (state == ACCESS) & iPREADY;
    assign grant     = (state == IDLE) & (wr_pend | rd_pend);
    // pwrite_q still holds the type of the last grant, so it doubles as the round-robin pointer
    assign pick_write = wr_pend & (~rd_pend | full | ~pwrite_q);
    assign slot       = pick_write ? head[29:26] : rd_addr_q;

`ifdef LAP_SEQ_OVERWRITE_EN
    logic head_gone, busy_write;
    assign busy_write = (state == IDLE) ? (grant & pick_write) : pwrite_q;
    assign pop        = xfer_done & pwrite_q & ~head_gone;
    assign drop       = push_evt & full & ~pop;
    assign push_ok    = push_evt;
    assign adv_rd     = pop | drop;

    // The in-flight head was already discarded by an overwrite; its completion must not pop again.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)               head_gone <= 1'b0;
        else if (xfer_done)         head_gone <= 1'b0;
        else if (drop & busy_write) head_gone <= 1'b1;
    end
`else
    assign pop     = xfer_done & pwrite_q;
    assign drop    = push_evt & full & ~pop;
    assign push_ok = push_evt & ~drop;
    assign adv_rd  = pop;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lap_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            lap_q  <= iLAP_STORE;
            drop_q <= drop;
            if (push_ok) wr_ptr <= wr_ptr + ONE;
            if (adv_rd)  rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge pclk) begin
        if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= {iLAP_ADDR, iLAP};
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (iPREADY) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // APB outputs are computed one cycle ahead so that the bus comes straight from flops.
    always_comb begin
        psel_d    = (next_state != IDLE);
        penable_d = (next_state == ACCESS);
        pwrite_d  = pwrite_q;
        pstrb_d   = pstrb_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        if (grant) begin
            pwrite_d = pick_write;
            pstrb_d  = pick_write ? 4'hF : 4'h0;
            paddr_d  = BASE_ADDR + {10'b0, slot, 2'b00};
            pwdata_d = pick_write ? {6'b0, head[25:0]} : 32'h0;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pstrb_q   <= 4'h0;
            paddr_q   <= 16'h0;
            pwdata_q  <= 32'h0;
        end else begin
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            pstrb_q   <= pstrb_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rd_pend    <= 1'b0;
            rd_addr_q  <= 4'h0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 26'h0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= xfer_done & ~pwrite_q;
            if (xfer_done & ~pwrite_q) begin
                rd_data_q <= iPRDATA[25:0];
                rd_pend   <= 1'b0;
            end else if (iRD_REQ & ~rd_pend) begin
                rd_pend   <= 1'b1;
                rd_addr_q <= iRD_ADDR;
            end
            if (xfer_done & iPSLVERR) err_q <= 1'b1;
            else if (iERR_CLR)        err_q <= 1'b0;
        end
    end

    assign oRD_VALID  = rd_valid_q;
    assign oRD_DATA   = rd_data_q;
    assign oRD_BUSY   = rd_pend;
    assign oFIFO_FULL = full;
    assign oDROP      = drop_q;
    assign oERR       = err_q;
    assign oPSEL      = psel_q;
    assign oPENABLE   = penable_q;
    assign oPWRITE    = pwrite_q;
    assign oPSTRB     = pstrb_q;
    assign oPADDR     = paddr_q;
    assign oPWDATA    = pwdata_q;
endmodule

// File: tb/tb_lap_sram_sequencer.sv
// tb/tb_lap_sram_sequencer.sv - directed self-checking bench for lap_sram_sequencer
module tb_lap_sram_sequencer;
    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        lap_store = 1'b0;
    logic [25:0] lap = '0;
    logic [3:0]  lap_addr = '0;
    logic        rd_req = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic        err_clr = 1'b0;
    logic        rd_valid, rd_busy, fifo_full, drop, err, psel, penable, pwrite;
    logic [25:0] rd_data;
    logic [3:0]  pstrb;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int stall = 0;
    bit hold = 1'b0;
    bit err_inj = 1'b0;
    int drop_cnt = 0;
    logic [52:0] xlog [$];
    logic [25:0] rd_log [$];
    logic [31:0] sram [16];

    always #5 pclk = ~pclk;

    lap_sram_sequencer #(.DEPTH(4), .BASE_ADDR(16'h0000)) dut (
        .pclk(pclk), .presetn(presetn),
        .iLAP_STORE(lap_store), .iLAP(lap), .iLAP_ADDR(lap_addr),
        .iRD_REQ(rd_req), .iRD_ADDR(rd_addr), .iERR_CLR(err_clr),
        .oRD_VALID(rd_valid), .oRD_DATA(rd_data), .oRD_BUSY(rd_busy),
        .oFIFO_FULL(fifo_full), .oDROP(drop), .oERR(err),
        .oPSEL(psel), .oPENABLE(penable), .oPWRITE(pwrite), .oPSTRB(pstrb),
        .oPADDR(paddr), .oPWDATA(pwdata),
        .iPRDATA(prdata), .iPREADY(pready), .iPSLVERR(pslverr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [52:0] xw(input logic [15:0] a, input logic [25:0] v);
        return {1'b1, a, 6'b0, v, 4'hF};
    endfunction

    function automatic logic [52:0] xr(input logic [15:0] a);
        return {1'b0, a, 32'h0, 4'h0};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic lap_edge(input logic [3:0] a, input logic [25:0] v);
        lap_addr  = a;
        lap       = v;
        lap_store = 1'b1;
        step(1);
        lap_store = 1'b0;
        step(1);
    endtask

    task automatic wait_log(input int n, input string tag);
        int k;
        k = 0;
        while (xlog.size() < n && k < 300) begin step(1); k++; end
        check(tag, 64'(xlog.size() >= n), 64'd1);
    endtask

    task automatic wait_rd(input int n, input string tag);
        int k;
        k = 0;
        while (rd_log.size() < n && k < 300) begin step(1); k++; end
        check(tag, 64'(rd_log.size() >= n), 64'd1);
    endtask

    // APB slave model: answers after `stall` ACCESS cycles, logs each transfer, checks the handshake shape.
    initial begin : slave
        int acc_n, setup_n;
        bit prev_rdy;
        logic [52:0] cur, setup_v;
        acc_n = 0; setup_n = 0; prev_rdy = 1'b0; setup_v = '0;
        for (int i = 0; i < 16; i++) sram[i] = 32'hFC00_0000 | i;
        forever begin
            @(negedge pclk);
            pready  = 1'b0;
            pslverr = 1'b0;
            if (prev_rdy) check("idle_gap", 64'(psel), 64'd0);
            prev_rdy = 1'b0;
            cur = {pwrite, paddr, pwdata, pstrb};
            if (!psel) begin
                acc_n = 0; setup_n = 0;
            end else if (!penable) begin
                setup_n++;
                setup_v = cur;
            end else begin
                if (acc_n == 0) check("setup_len", 64'(setup_n), 64'd1);
                if (!hold && acc_n >= stall) begin
                    check("apb_stable", 64'(cur), 64'(setup_v));
                    pready  = 1'b1;
                    pslverr = err_inj;
                    prdata  = sram[paddr[5:2]];
                    if (pwrite) sram[paddr[5:2]] = pwdata;
                    xlog.push_back(cur);
                    prev_rdy = 1'b1;
                end
                acc_n++;
            end
        end
    end

    initial begin : host_mon
        forever begin
            @(negedge pclk);
            if (rd_valid) rd_log.push_back(rd_data);
            if (drop) drop_cnt++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int base, rb, d0, k;
        step(3);
        check("rst_apb", {psel, penable, pwrite, pstrb, paddr, pwdata}, 64'd0);
        check("rst_host", {rd_valid, rd_data, rd_busy, fifo_full, drop, err}, 64'd0);
        presetn = 1'b1;
        step(2);
        check("post_rst_psel", 64'(psel), 64'd0);

        // contention: W,R,W,R,W with round-robin starting at write
        stall = 3;
        base = xlog.size();
        rb = rd_log.size();
        lap_addr = 4'd1; lap = 26'hAAA; lap_store = 1'b1;
        rd_addr = 4'd2; rd_req = 1'b1;
        step(1);
        lap_store = 1'b0; rd_req = 1'b0;
        step(1);
        lap_edge(4'd4, 26'hBBB);
        wait_log(base + 2, "cont_wait2");
        k = 0;
        while (rd_busy && k < 50) begin step(1); k++; end
        rd_addr = 4'd6; rd_req = 1'b1;
        lap_edge(4'd7, 26'hCCC);
        rd_req = 1'b0;
        wait_log(base + 5, "cont_wait5");
        check("cont_x0", xlog[base],   xw(16'h0004, 26'hAAA));
        check("cont_x1", xlog[base+1], xr(16'h0008));
        check("cont_x2", xlog[base+2], xw(16'h0010, 26'hBBB));
        check("cont_x3", xlog[base+3], xr(16'h0018));
        check("cont_x4", xlog[base+4], xw(16'h001C, 26'hCCC));
        wait_rd(rb + 2, "cont_rd_wait");
        check("cont_rd0", 64'(rd_log[rb]),   64'h2);
        check("cont_rd1", 64'(rd_log[rb+1]), 64'h6);
        stall = 0;
        step(4);

        // single lap
        base = xlog.size();
        lap_edge(4'd3, 26'h0000123);
        wait_log(base + 1, "single_wait");
        check("single_x", xlog[base], xw(16'h000C, 26'h0000123));
        step(4);

        // level held for 10 cycles
        base = xlog.size();
        lap_addr = 4'd9; lap = 26'h55; lap_store = 1'b1;
        step(10);
        lap_store = 1'b0;
        step(10);
        check("level_once", 64'(xlog.size() - base), 64'd1);
        check("level_x", xlog[base], xw(16'h0024, 26'h55));

        // overflow while slave stalls
        hold = 1'b1;
        base = xlog.size();
        d0 = drop_cnt;
        for (int i = 0; i < 5; i++) lap_edge(4'(8 + i), 26'(26'h100 + i));
        check("ovf_full", 64'(fifo_full), 64'd1);
        check("ovf_drop", 64'(drop_cnt - d0), 64'd1);
        check("ovf_nowrite", 64'(xlog.size() - base), 64'd0);
        hold = 1'b0;
        wait_log(base + 4, "ovf_wait");
        for (int i = 0; i < 4; i++)
            check("ovf_x", xlog[base+i], xw(16'(16'h0020 + 4*i), 26'(26'h100 + i)));
        step(6);
        check("ovf_count", 64'(xlog.size() - base), 64'd4);
        check("ovf_notfull", 64'(fifo_full), 64'd0);

        // readback of slot 15, second request while busy ignored
        base = xlog.size();
        lap_edge(4'd15, 26'h3FFFFFF);
        wait_log(base + 1, "rb_wr_wait");
        check("rb_wr", xlog[base], xw(16'h003C, 26'h3FFFFFF));
        step(2);
        rb = rd_log.size();
        rd_addr = 4'd15; rd_req = 1'b1;
        step(1);
        rd_req = 1'b0;
        check("rb_busy", 64'(rd_busy), 64'd1);
        rd_addr = 4'd3; rd_req = 1'b1;
        step(1);
        rd_req = 1'b0;
        wait_log(base + 2, "rb_rd_wait");
        check("rb_rd", xlog[base+1], xr(16'h003C));
        wait_rd(rb + 1, "rb_valid_wait");
        check("rb_data", 64'(rd_log[rb]), 64'h3FFFFFF);
        step(10);
        check("rb_ignored", 64'(xlog.size() - base), 64'd2);
        check("rb_idle", 64'(rd_busy), 64'd0);

        // slave error on a write
        base = xlog.size();
        err_inj = 1'b1;
        lap_edge(4'd0, 26'h7);
        wait_log(base + 1, "err_wait");
        err_inj = 1'b0;
        step(2);
        check("err_x", xlog[base], xw(16'h0000, 26'h7));
        check("err_set", 64'(err), 64'd1);
        step(10);
        check("err_popped", 64'(xlog.size() - base), 64'd1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("err_clr", 64'(err), 64'd0);

        // reset in the middle of ACCESS
        hold = 1'b1;
        base = xlog.size();
        rb = rd_log.size();
        for (int i = 0; i < 4; i++) lap_edge(4'(1 + i), 26'(26'h200 + i));
        rd_addr = 4'd5; rd_req = 1'b1;
        step(1);
        rd_req = 1'b0;
        k = 0;
        while (!(psel && penable) && k < 50) begin step(1); k++; end
        check("mid_access", 64'({psel, penable}), 64'h3);
        check("mid_full", 64'(fifo_full), 64'd1);
        check("mid_busy", 64'(rd_busy), 64'd1);
        #2 presetn = 1'b0;
        #1;
        check("rst_psel", 64'({psel, penable}), 64'h0);
        check("rst_full", 64'(fifo_full), 64'd0);
        check("rst_busy", 64'(rd_busy), 64'd0);
        @(negedge pclk);
        presetn = 1'b1;
        hold = 1'b0;
        step(20);
        check("rst_flush", 64'(xlog.size() - base), 64'd0);
        check("rst_no_rd", 64'(rd_log.size() - rb), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
